// File: rtl/ps2_key_sender.sv
// Purpose: device-side PS/2 keyboard transmitter; one accepted scan code becomes make/F0/make frames (or make only).
// Latency: start bit is on the line the cycle after accept; busy for 66*CLK_HALF+2*GAP_CYCLES (mode 0) or 22*CLK_HALF (mode 1).
// Backpressure: key_ready is low while a key is in flight; key_valid seen then is dropped, not queued.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   key_code, key_mode  scan code and mode (0 = make/break/make, 1 = make only), latched on accept
//   key_valid/key_ready request handshake; key_ready is registered and high in IDLE and DONE
//   busy, done          busy from the cycle after accept to the end of the last frame; done pulses once
//   PS2_clk, PS2_dat    PS/2 line outputs, both idle high
module ps2_key_sender #(
    parameter int         CLK_HALF   = 4,
    parameter int         GAP_CYCLES = 6,
    parameter logic [7:0] STOP_CODE  = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_code,
    input  logic       key_mode,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       busy,
    output logic       done,
    output logic       PS2_clk,
    output logic       PS2_dat
);

    // One counter times both the clock half-periods and the inter-byte gap,
    // so it is sized for whichever of the two is longer.
    localparam int CNT_MAX = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_HALF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIT_HI,
        S_BIT_LO,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       code_q, code_d;
    logic             mode_q, mode_d;
    logic             key_ready_q, key_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ps2_clk_q, ps2_clk_d;
    logic             ps2_dat_q, ps2_dat_d;

    logic       accept;
    logic [7:0] cur_byte;
    logic       last_byte;
    logic [3:0] bit_idx_nxt;

    // Line value of frame bit idx: start, 8 data bits LSB first, odd parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [3:0] k;
        k = idx - 4'd1;
        case (idx)
            4'd0:                                           frame_bit = 1'b0;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: frame_bit = b[k[2:0]];
            4'd9:                                           frame_bit = ~^b;
            default:                                        frame_bit = 1'b1;
        endcase
    endfunction

    assign accept      = key_valid && key_ready_q;
    // Byte 1 of a press/release sequence is always the break prefix.
    assign cur_byte    = (byte_idx_q == 2'd1) ? STOP_CODE : code_q;
    assign last_byte   = (byte_idx_q == 2'd2) || ((byte_idx_q == 2'd0) && mode_q);
    assign bit_idx_nxt = bit_idx_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        code_d      = code_q;
        mode_d      = mode_q;
        key_ready_d = key_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ps2_clk_d   = ps2_clk_q;
        ps2_dat_d   = ps2_dat_q;

        case (state_q)
            // DONE behaves like IDLE for acceptance so a held request
            // restarts after exactly one idle-high cycle.
            S_IDLE, S_DONE: begin
                state_d     = S_IDLE;
                key_ready_d = 1'b1;
                busy_d      = 1'b0;
                ps2_clk_d   = 1'b1;
                ps2_dat_d   = 1'b1;
                if (accept) begin
                    code_d      = key_code;
                    mode_d      = key_mode;
                    byte_idx_d  = 2'd0;
                    bit_idx_d   = 4'd0;
                    cnt_d       = '0;
                    key_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    ps2_dat_d   = 1'b0;
                    state_d     = S_BIT_HI;
                end
            end
            S_BIT_HI: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    ps2_clk_d = 1'b0;
                    state_d   = S_BIT_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BIT_LO: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    ps2_clk_d = 1'b1;
                    if (bit_idx_q < 4'd10) begin
                        // Data moves together with the rising clock edge.
                        bit_idx_d = bit_idx_nxt;
                        ps2_dat_d = frame_bit(cur_byte, bit_idx_nxt);
                        state_d   = S_BIT_HI;
                    end else begin
                        ps2_dat_d = 1'b1;
                        if (last_byte) begin
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            key_ready_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d      = '0;
                    byte_idx_d = byte_idx_q + 2'd1;
                    bit_idx_d  = 4'd0;
                    ps2_dat_d  = 1'b0;
                    state_d    = S_BIT_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 4'd0;
            byte_idx_q  <= 2'd0;
            code_q      <= 8'd0;
            mode_q      <= 1'b0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ps2_clk_q   <= 1'b1;
            ps2_dat_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            code_q      <= code_d;
            mode_q      <= mode_d;
            key_ready_q <= key_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ps2_clk_q   <= ps2_clk_d;
            ps2_dat_q   <= ps2_dat_d;
        end
    end

    assign key_ready = key_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign PS2_clk   = ps2_clk_q;
    assign PS2_dat   = ps2_dat_q;

endmodule
